mac_accum_array: RTL and testbench
==================================

// Module: mac_accum_array
// PURPOSE
//  Streaming signed dot-product engine: up to MAX_MACS int lanes multiplied per beat, reduced by a
//  fully registered adder tree, accumulated across beats until in_last, then emitted with bias added.
//  Sits between the NPU operand fetch and the requantisation stage; successor to the single-beat MAC.
// PARAMETERS
//  MAX_MACS    64  lanes per beat (power of two, >=1)
//  DATA_WIDTH  8   signed operand width
//  ACC_WIDTH   32  accumulator/output width (>= 2*DATA_WIDTH+$clog2(MAX_MACS)+1)
// PORTS
//  clk          in   1                       clock
//  rst          in   1                       reset (see BEHAVIOUR)
//  cfg_num_macs in   $clog2(MAX_MACS+1)      active lanes for this beat
//  in_valid     in   1                       beat valid
//  in_ready     out  1                       beat accepted when in_valid&&in_ready
//  in_data      in   MAX_MACS*DATA_WIDTH     lane i = [i*DATA_WIDTH +: DATA_WIDTH], signed
//  in_weight    in   MAX_MACS*DATA_WIDTH     same packing, signed
//  in_bias      in   ACC_WIDTH               signed; sampled on first beat of a group only
//  in_last      in   1                       final beat of the dot product
//  in_zp        in   DATA_WIDTH              signed input zero point (only with MAC_ZP_EN)
//  out_valid    out  1                       result valid, held until out_ready
//  out_ready    in   1                       downstream accept
//  out_data     out  ACC_WIDTH               signed result
//  out_ovf      out  1                       accumulator overflow occurred in this group
// BEHAVIOUR
//  - One clock clk; reset rst is asynchronous, active-high. All state clears on rst: out_valid=0,
//    out_data=0, out_ovf=0, in_ready=0 while rst high; pipeline valids/accumulator/first flag cleared.
//  - Reset mid-group discards partial sums; next accepted beat is treated as first of a new group.
//  - Global stall: adv = !(out_valid && !out_ready). in_ready = adv (and !rst). All stages move on adv.
//  - Stage M (1 cycle): lane i product = data_i*weight_i if i < min(cfg_num_macs,MAX_MACS) else 0.
//    cfg_num_macs=0 -> beat contributes 0; values >MAX_MACS clamp to MAX_MACS. Sampled per beat.
//  - Stages T1..Tn, n=$clog2(MAX_MACS): one registered pairwise level each, sign-extended, no
//    truncation (level k width = 2*DATA_WIDTH+k). Valid/last/bias travel as sideband with data.
//  - Stage A: first beat: acc = bias + sum; else acc = acc + sum. Both sign-extended to ACC_WIDTH,
//    two's-complement wrap; ovf_sticky |= signed overflow of that add; cleared on first beat.
//  - When the beat at Stage A has last=1: out_data <= result, out_ovf <= sticky|this ovf,
//    out_valid <= 1; group ends, first flag set. Single-beat group (first&&last) legal.
//  - Latency accepted last beat -> out_valid: n+2 cycles (8 for MAX_MACS=64, 2 for MAX_MACS=1).
//  - Throughput 1 beat/cycle when out_ready=1; out_valid && out_ready in the same cycle a new
//    result arrives -> new result replaces, out_valid stays 1 (no bubble).
//  - out_data/out_ovf stable while out_valid && !out_ready.
// CONFIGURATION
//  - MAC_ZP_EN defined: in_zp port exists; operand = in_data_i - in_zp (DATA_WIDTH+1 bits signed),
//    product width 2*DATA_WIDTH+1, tree widths grow by one; in_zp sampled per beat.
//  - MAC_ZP_EN undefined: no in_zp port; operand = in_data_i directly.
// STRUCTURE
//  - Package npu_mac_pkg: PROD_W/TREE_W width functions, clamp_lanes() function, beat-sideband
//    struct/typedef {valid,last,first,bias}.
//  - Sub-module mac_adder_tree (param N, IN_W): registered reduction with enable, sideband pipe.
//  - Top holds multiplier stage, lane masking, accumulator, overflow logic, output register.
// TESTING
//  - Reset: rst high with stimulus active -> out_valid=0,out_data=0,in_ready=0; release, no spurious out.
//  - 4 beats, num_macs=64, all data=1, weight=2, bias=10, last on beat 4 -> out_data=522, 8 cycles after.
//  - num_macs=3, data={5,-3,7,99..}, weight={2,4,-1,99..}, bias=0, single beat -> out_data=-9.
//  - ACC_WIDTH=16 param run: bias=32767, one beat sum=+1 -> out_data=-32768, out_ovf=1; next group ovf=0.
//  - out_ready low 5 cycles while 3 groups stream -> in_ready drops, no result lost/duplicated, order kept.
//  - MAC_ZP_EN: zp=-128, data=-128 all lanes, weight=3, num_macs=64 -> out_data=0; data=0 -> 24576.

Source files
------------

// File: rtl/npu_mac_pkg.sv
// npu_mac_pkg: shared widths, lane clamp and beat sideband type for mac_accum_array
// MAC_ZP_EN widens operands by one bit for the zero-point subtraction.
package npu_mac_pkg;
`ifdef MAC_ZP_EN
  localparam int ZP_EXT = 1;
`else
  localparam int ZP_EXT = 0;
`endif
  typedef struct packed {
    logic valid;
    logic last;
    logic first;
  } beat_ctrl_t;
  function automatic int prod_w(int dw);
    return 2 * dw + ZP_EXT;
  endfunction
  function automatic int tree_w(int dw, int n);
    return prod_w(dw) + $clog2(n);
  endfunction
  function automatic int clamp_lanes(int n, int max_n);
    return (n > max_n) ? max_n : n;
  endfunction
endpackage

// File: rtl/mac_accum_array_if.sv
// mac_accum_array_if: beat input / result output bundle of mac_accum_array
// master drives beats and out_ready; slave (the engine) drives in_ready and results.
// in_zp exists only with MAC_ZP_EN.
interface mac_accum_array_if #(
  parameter int MAX_MACS   = 64,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
);
  logic [$clog2(MAX_MACS+1)-1:0] cfg_num_macs;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [MAX_MACS*DATA_WIDTH-1:0] in_data, in_weight;
  logic [ACC_WIDTH-1:0] in_bias, out_data;
`ifdef MAC_ZP_EN
  logic [DATA_WIDTH-1:0] in_zp;
`endif
  modport master (
    output cfg_num_macs, in_valid, in_data, in_weight, in_bias, in_last, out_ready,
`ifdef MAC_ZP_EN
    output in_zp,
`endif
    input in_ready, out_valid, out_data, out_ovf
  );
  modport slave (
    input cfg_num_macs, in_valid, in_data, in_weight, in_bias, in_last, out_ready,
`ifdef MAC_ZP_EN
    input in_zp,
`endif
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mac_adder_tree.sv
// mac_adder_tree: registered pairwise signed reduction of N lanes with a sideband pipe
// Ports: clk, rst (async, active-high), i_en (advance), i_data (N x IN_W signed),
//   i_sb (sideband in), o_sum (IN_W+$clog2(N) signed), o_sb (sideband aligned with o_sum).
// Each level widens by one bit so nothing is truncated; N=1 is a plain wire.
module mac_adder_tree #(
  parameter int N    = 64,
  parameter int IN_W = 16,
  parameter int SB_W = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic [N*IN_W-1:0]             i_data,
  input  logic [SB_W-1:0]               i_sb,
  output logic [IN_W+$clog2(N)-1:0]     o_sum,
  output logic [SB_W-1:0]               o_sb
);
  localparam int L = $clog2(N);
  if (L == 0) begin : g_pass
    assign o_sum = i_data;
    assign o_sb  = i_sb;
  end else begin : g_tree
    for (genvar k = 1; k <= L; k++) begin : g_lvl
      localparam int W = IN_W + k;
      localparam int C = N >> k;
      logic [C*W-1:0] r_sum;
      logic [SB_W-1:0] r_sb;
      logic [2*C*(W-1)-1:0] w_prev;
      logic [SB_W-1:0] w_psb;
      if (k == 1) begin : g_src
        assign w_prev = i_data;
        assign w_psb  = i_sb;
      end else begin : g_src
        assign w_prev = g_lvl[k-1].r_sum;
        assign w_psb  = g_lvl[k-1].r_sb;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum <= '0;
          r_sb  <= '0;
        end else if (i_en) begin
          for (int j = 0; j < C; j++)
            r_sum[j*W +: W] <= W'($signed(w_prev[2*j*(W-1) +: W-1])) + W'($signed(w_prev[(2*j+1)*(W-1) +: W-1]));
          r_sb <= w_psb;
        end
      end
    end
    assign o_sum = g_lvl[L].r_sum;
    assign o_sb  = g_lvl[L].r_sb;
  end
endmodule

// File: rtl/mac_accum_array.sv
// mac_accum_array: streaming signed dot-product engine with bias, beat accumulation and overflow flag
// Ports: clk, rst (async, active-high), bus (mac_accum_array_if.slave: cfg_num_macs, in_valid/in_ready,
//   in_data, in_weight, in_bias, in_last, [in_zp], out_valid/out_ready, out_data, out_ovf).
// Optional MAC_ZP_EN: subtract in_zp from every data lane before multiplying.
// Pipeline: multiply (1) -> adder tree ($clog2(MAX_MACS)) -> accumulate/output (1); one global stall.
module mac_accum_array
  import npu_mac_pkg::*;
#(
  parameter int MAX_MACS   = 64,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input logic              clk,
  input logic              rst,
  mac_accum_array_if.slave bus
);
  localparam int OW   = DATA_WIDTH + ZP_EXT;
  localparam int PW   = prod_w(DATA_WIDTH);
  localparam int TW   = tree_w(DATA_WIDTH, MAX_MACS);
  localparam int CB   = $bits(beat_ctrl_t);
  localparam int SB_W = CB + ACC_WIDTH;
  logic w_adv, w_acc, w_ovf, w_ovf_grp;
  logic r_in_first, r_sticky, r_out_valid, r_out_ovf;
  int w_lanes;
  logic [MAX_MACS*PW-1:0] w_prod, r_m_prod;
  logic [SB_W-1:0] w_sb, r_m_sb, w_t_sb;
  logic [TW-1:0] w_t_sum;
  beat_ctrl_t w_in_ctl, w_a_ctl;
  logic signed [ACC_WIDTH-1:0] w_sum, w_base, w_res, r_acc, r_out_data;
  assign w_adv = !(r_out_valid && !bus.out_ready);
  assign bus.in_ready  = w_adv && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign w_acc   = bus.in_valid && bus.in_ready;
  assign w_lanes = clamp_lanes(int'(bus.cfg_num_macs), MAX_MACS);
  for (genvar i = 0; i < MAX_MACS; i++) begin : g_lane
    logic signed [OW-1:0] w_op;
`ifdef MAC_ZP_EN
    assign w_op = OW'($signed(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH])) - OW'($signed(bus.in_zp));
`else
    assign w_op = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
`endif
    assign w_prod[i*PW +: PW] = (i < w_lanes) ? PW'(w_op) * PW'($signed(bus.in_weight[i*DATA_WIDTH +: DATA_WIDTH])) : '0;
  end
  // first-of-group is decided at acceptance so it travels with the beat it belongs to
  assign w_in_ctl = '{valid: w_acc, last: bus.in_last, first: r_in_first};
  assign w_sb     = {w_in_ctl, bus.in_bias};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_prod   <= '0;
      r_m_sb     <= '0;
      r_in_first <= 1'b1;
    end else if (w_adv) begin
      r_m_prod <= w_prod;
      r_m_sb   <= w_sb;
      if (w_acc) r_in_first <= bus.in_last;
    end
  end
  mac_adder_tree #(.N(MAX_MACS), .IN_W(PW), .SB_W(SB_W)) u_tree (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_adv),
    .i_data (r_m_prod),
    .i_sb   (r_m_sb),
    .o_sum  (w_t_sum),
    .o_sb   (w_t_sb)
  );
  assign w_a_ctl = w_t_sb[SB_W-1 -: CB];
  assign w_sum   = ACC_WIDTH'($signed(w_t_sum));
  assign w_base  = w_a_ctl.first ? w_t_sb[ACC_WIDTH-1:0] : r_acc;
  assign w_res   = w_base + w_sum;
  // signed overflow: operands agree in sign but the wrapped result does not
  assign w_ovf     = (w_base[ACC_WIDTH-1] == w_sum[ACC_WIDTH-1]) && (w_res[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]);
  assign w_ovf_grp = w_ovf || (!w_a_ctl.first && r_sticky);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_a_ctl.valid && w_a_ctl.last;
      if (w_a_ctl.valid) begin
        r_acc    <= w_res;
        r_sticky <= w_ovf_grp;
        if (w_a_ctl.last) begin
          r_out_data <= w_res;
          r_out_ovf  <= w_ovf_grp;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_accum_array.sv
// tb_mac_accum_array: scoreboard bench for mac_accum_array (64-lane/32-bit and 4-lane/16-bit builds)
module tb_mac_accum_array;
  localparam int MM = 64, DW = 8, AW = 32, CW = $clog2(MM + 1), LAT = $clog2(MM) + 2;
  localparam int MM2 = 4, DW2 = 4, AW2 = 16, CW2 = $clog2(MM2 + 1);
  typedef struct {longint d; bit o;} exp_t;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  mac_accum_array_if #(.MAX_MACS(MM), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus();
  mac_accum_array_if #(.MAX_MACS(MM2), .DATA_WIDTH(DW2), .ACC_WIDTH(AW2)) bus16();
  mac_accum_array #(.MAX_MACS(MM), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  mac_accum_array #(.MAX_MACS(MM2), .DATA_WIDTH(DW2), .ACC_WIDTH(AW2)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  exp_t q[$], q16[$];
  exp_t got, got16;
  int checks = 0, errors = 0, rdy_mode = 0, sc = 0, stall_cycles = 0, lat, snap;
  logic signed [DW-1:0] bd [MM], bw [MM];
  longint zp = 0, m_acc = 0, m16_acc = 0;
  bit m_ovf = 0, m_first = 1, m16_ovf = 0, m16_first = 1, held = 0;
  logic [AW-1:0] hold_d;
  bit hold_o;

  function automatic longint wrap(longint e, int w);
    longint m = longint'(1) << w;
    longint r = e & (m - 1);
    return (r >= (m >> 1)) ? r - m : r;
  endfunction
  // reference: exact add, flag when the true sum leaves the signed range, then wrap
  function automatic void acc_step(input longint s, input longint b, input int w, input bit first,
                                   inout longint acc, inout bit ovf);
    longint e = (first ? b : acc) + s;
    ovf = (first ? 1'b0 : ovf) | (e >= (longint'(1) << (w - 1)) || e < -(longint'(1) << (w - 1)));
    acc = wrap(e, w);
  endfunction
  function automatic longint beat_sum(int nm);
    longint s = 0;
    for (int i = 0; i < ((nm > MM) ? MM : nm); i++) s += (longint'(bd[i]) - zp) * longint'(bw[i]);
    return s;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int nm, input bit last, input longint bias);
    int n = 0;
    bus.cfg_num_macs = CW'(nm);
    for (int i = 0; i < MM; i++) begin
      bus.in_data[i*DW +: DW]   = bd[i];
      bus.in_weight[i*DW +: DW] = bw[i];
    end
    bus.in_bias = AW'(bias);
    bus.in_last = last;
`ifdef MAC_ZP_EN
    bus.in_zp = DW'(zp);
`endif
    bus.in_valid = 1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    stall_cycles += n;
    chk("accept", longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    acc_step(beat_sum(nm), bias, AW, m_first, m_acc, m_ovf);
    if (last) q.push_back('{m_acc, m_ovf});
    m_first = last;
  endtask

  task automatic send16(input int d0, input bit last, input longint bias);
    int n = 0;
    bus16.cfg_num_macs = CW2'(1);
    bus16.in_data = '0;
    bus16.in_data[DW2-1:0] = DW2'(d0);
    bus16.in_weight = {MM2{4'd1}};
    bus16.in_bias = AW2'(bias);
    bus16.in_last = last;
    bus16.in_valid = 1;
    @(negedge clk);
    while (!bus16.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("accept16", longint'(bus16.in_ready), 1);
    @(posedge clk);
    #1;
    bus16.in_valid = 0;
    acc_step(longint'(d0), bias, AW2, m16_first, m16_acc, m16_ovf);
    if (last) q16.push_back('{m16_acc, m16_ovf});
    m16_first = last;
  endtask

  task automatic wait_result(input string nm, input longint ed, input bit eo, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 40);
    chk({nm, "_valid"}, longint'(bus.out_valid), 1);
    chk({nm, "_data"}, longint'($signed(bus.out_data)), ed);
    chk({nm, "_ovf"}, longint'(bus.out_ovf), longint'(eo));
    @(posedge clk);
    #1;
  endtask

  task automatic wait16(input string nm, input longint ed, input bit eo);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus16.out_valid && k < 40);
    chk({nm, "_valid"}, longint'(bus16.out_valid), 1);
    chk({nm, "_data"}, longint'($signed(bus16.out_data)), ed);
    chk({nm, "_ovf"}, longint'(bus16.out_ovf), longint'(eo));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q16.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size() + q16.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int d, input int w);
    for (int i = 0; i < MM; i++) begin
      bd[i] = DW'(d);
      bw[i] = DW'(w);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < MM; i++) begin
      bd[i] = DW'($urandom());
      bw[i] = DW'($urandom());
    end
  endtask

  // out_ready owner: 0 always ready, 1 random, 2 low until a result has waited 5 cycles
  initial begin
    bus.out_ready = 1;
    bus16.out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      sc = (rdy_mode != 2) ? 0 : (bus.out_valid ? sc + 1 : sc);
      bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : (sc >= 5);
    end
  end

  always @(negedge clk) begin
    if (rst) held = 0;
    else begin
      chk("in_ready_rule", longint'(bus.in_ready), longint'(!(bus.out_valid && !bus.out_ready)));
      if (held) begin
        chk("hold_valid", longint'(bus.out_valid), 1);
        chk("hold_data", longint'(bus.out_data), longint'(hold_d));
        chk("hold_ovf", longint'(bus.out_ovf), longint'(hold_o));
      end
      held = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      hold_o = bus.out_ovf;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("spurious_result", 1, 0);
        else begin
          got = q.pop_front();
          chk("result_data", longint'($signed(bus.out_data)), got.d);
          chk("result_ovf", longint'(bus.out_ovf), longint'(got.o));
        end
      end
      if (bus16.out_valid && bus16.out_ready) begin
        if (q16.size() == 0) chk("spurious_result16", 1, 0);
        else begin
          got16 = q16.pop_front();
          chk("result16_data", longint'($signed(bus16.out_data)), got16.d);
          chk("result16_ovf", longint'(bus16.out_ovf), longint'(got16.o));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_rand();
    for (int i = 0; i < MM; i++) begin
      bus.in_data[i*DW +: DW] = bd[i];
      bus.in_weight[i*DW +: DW] = bw[i];
    end
    bus.cfg_num_macs = CW'(MM);
    bus.in_bias = AW'(123);
    bus.in_last = 1;
    bus.in_valid = 1;
    bus16.cfg_num_macs = '0;
    bus16.in_data = '0;
    bus16.in_weight = '0;
    bus16.in_bias = '0;
    bus16.in_last = 0;
    bus16.in_valid = 0;
`ifdef MAC_ZP_EN
    bus.in_zp = '0;
    bus16.in_zp = '0;
`endif
    #1 rst = 1;
    repeat (4) @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_out_ovf", longint'(bus.out_ovf), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 0);
    bus.in_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", longint'(bus.out_valid), 0);
    @(posedge clk);
    #1;

    fill(1, 2);
    for (int b = 0; b < 4; b++) send(MM, b == 3, 10);
    wait_result("dot4", 522, 0, lat);
    chk("dot4_latency", lat, LAT);

    fill(99, 99);
    bd[0] = 5; bd[1] = -3; bd[2] = 7;
    bw[0] = 2; bw[1] = 4;  bw[2] = -1;
    send(3, 1, 0);
    wait_result("lanes3", -9, 0, lat);

    fill(1, 1);
    send(0, 1, 5);
    wait_result("lanes0", 5, 0, lat);
    send(100, 1, 0);
    wait_result("clamp", 64, 0, lat);
    drain();

    send16(1, 1, 32767);
    wait16("ovf16", -32768, 1);
    send16(5, 1, 0);
    wait16("noovf16", 5, 0);
    send16(1, 0, 32767);
    send16(-1, 1, 0);
    wait16("sticky16", 32767, 1);
    drain();

    fill_rand();
    send(MM, 0, 7);
    send(MM, 0, 7);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("midrst_in_ready", longint'(bus.in_ready), 0);
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    @(posedge clk);
    #1 rst = 0;
    m_first = 1;
    m16_first = 1;
    repeat (12) @(posedge clk);
    #1;
    fill(2, 3);
    send(10, 1, -4);
    wait_result("after_rst", 56, 0, lat);
    drain();

    rdy_mode = 2;
    snap = stall_cycles;
    for (int g = 0; g < 3; g++)
      for (int b = 0; b < 6; b++) begin
        fill_rand();
        send(MM, b == 5, longint'($signed($urandom())));
      end
    drain();
    chk("stall_in_ready_dropped", longint'(stall_cycles > snap), 1);
    rdy_mode = 0;

`ifdef MAC_ZP_EN
    zp = -128;
    fill(-128, 3);
    send(MM, 1, 0);
    wait_result("zp_zero", 0, 0, lat);
    fill(0, 3);
    send(MM, 1, 0);
    wait_result("zp_full", 24576, 0, lat);
    drain();
`endif

    rdy_mode = 1;
    for (int g = 0; g < 40; g++) begin
      int len = $urandom_range(1, 4);
      longint bias = longint'($signed($urandom()));
      for (int b = 0; b < len; b++) begin
        fill_rand();
`ifdef MAC_ZP_EN
        zp = longint'($urandom_range(0, 255)) - 128;
`endif
        send($urandom_range(0, 70), b == len - 1, bias);
      end
    end
    drain();
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
